// File: rtl/dm_sram_bridge.sv
// Data-memory responder: turns a single MEM-stage load/store request into a
// multi-cycle access on an external asynchronous 32-bit SRAM.
module dm_sram_bridge #(
    parameter int ADDR_W  = 20,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dm_re_i,
    input  logic              dm_we_i,
    input  logic [31:0]       dm_addr_i,
    input  logic [3:0]        dm_wbe_n_i,
    input  logic [31:0]       dm_wdata_i,
    output logic [31:0]       dm_rdata_o,
    output logic              dm_stall_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic [3:0]        sram_be_n_o,
    output logic [31:0]       sram_wdata_o,
    output logic              sram_data_oe_o,
    input  logic [31:0]       sram_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_WR_REC,
        S_DONE
    } state_t;

    state_t     state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic [3:0] wbe_q;
    logic       req, accept, last;
    logic       ce_n_d, oe_n_d, we_n_d, data_oe_d;
    logic [3:0] be_n_d;
    logic       addr_unused;

    assign req         = (dm_re_i | dm_we_i) & (dm_wbe_n_i != 4'hF);
    assign accept      = (state == S_IDLE) & req;
    assign addr_unused = ^{dm_addr_i[31:ADDR_W+2], dm_addr_i[1:0]};

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        last     = (cnt == '0);
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (dm_we_i) begin
                        state_nx = S_WR;
                        cnt_nx   = 3'(WR_WAIT);
                    end else begin
                        state_nx = S_RD;
                        cnt_nx   = 3'(RD_WAIT);
                    end
                end
            end
            S_RD: begin
                if (last) state_nx = S_DONE;
                else      cnt_nx   = cnt - 3'd1;
            end
            S_WR: begin
                if (last) state_nx = S_WR_REC;
                else      cnt_nx   = cnt - 3'd1;
            end
            S_WR_REC: state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase

        dm_stall_o = accept || (state == S_RD) || (state == S_WR) || (state == S_WR_REC);

        // Strobes are decoded from the next state and registered, so they line
        // up with the state they belong to without combinational glitches.
        ce_n_d    = !((state_nx == S_RD) || (state_nx == S_WR) || (state_nx == S_WR_REC));
        oe_n_d    = (state_nx != S_RD);
        we_n_d    = (state_nx != S_WR);
        data_oe_d = (state_nx == S_WR) || (state_nx == S_WR_REC);
        be_n_d    = 4'hF;
        if (state_nx == S_RD)
            be_n_d = 4'h0;
        else if ((state_nx == S_WR) || (state_nx == S_WR_REC))
            be_n_d = accept ? dm_wbe_n_i : wbe_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            wbe_q          <= '1;
            sram_addr_o    <= '0;
            sram_wdata_o   <= '0;
            dm_rdata_o     <= '0;
            sram_ce_n_o    <= 1'b1;
            sram_oe_n_o    <= 1'b1;
            sram_we_n_o    <= 1'b1;
            sram_be_n_o    <= '1;
            sram_data_oe_o <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            sram_ce_n_o    <= ce_n_d;
            sram_oe_n_o    <= oe_n_d;
            sram_we_n_o    <= we_n_d;
            sram_be_n_o    <= be_n_d;
            sram_data_oe_o <= data_oe_d;
            if (accept) begin
                sram_addr_o  <= dm_addr_i[ADDR_W+1:2];
                wbe_q        <= dm_wbe_n_i;
                sram_wdata_o <= dm_wdata_i;
            end
            if ((state == S_RD) && last)
                dm_rdata_o <= sram_rdata_i;
        end
    end

endmodule

// File: tb/tb_dm_sram_bridge.sv
// Directed bench for dm_sram_bridge: one instance with one-cycle waits, one
// zero-wait instance, each attached to a small behavioural SRAM.
module tb_dm_sram_bridge;

    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init = 1'b1;
    always #5 clk = ~clk;

    logic          re      [2];
    logic          we      [2];
    logic [31:0]   addr_i  [2];
    logic [3:0]    wbe_n   [2];
    logic [31:0]   wdata_i [2];
    logic [31:0]   rdata   [2];
    logic          stall   [2];
    logic [AW-1:0] s_addr  [2];
    logic          ce_n    [2];
    logic          oe_n    [2];
    logic          we_n    [2];
    logic [3:0]    be_n    [2];
    logic [31:0]   s_wdata [2];
    logic          d_oe    [2];
    logic [31:0]   s_rdata [2];

    dm_sram_bridge #(.ADDR_W(AW), .RD_WAIT(1), .WR_WAIT(1)) u0 (
        .clk(clk), .rst(rst), .dm_re_i(re[0]), .dm_we_i(we[0]), .dm_addr_i(addr_i[0]),
        .dm_wbe_n_i(wbe_n[0]), .dm_wdata_i(wdata_i[0]), .dm_rdata_o(rdata[0]),
        .dm_stall_o(stall[0]), .sram_addr_o(s_addr[0]), .sram_ce_n_o(ce_n[0]),
        .sram_oe_n_o(oe_n[0]), .sram_we_n_o(we_n[0]), .sram_be_n_o(be_n[0]),
        .sram_wdata_o(s_wdata[0]), .sram_data_oe_o(d_oe[0]), .sram_rdata_i(s_rdata[0])
    );

    dm_sram_bridge #(.ADDR_W(AW), .RD_WAIT(0), .WR_WAIT(0)) u1 (
        .clk(clk), .rst(rst), .dm_re_i(re[1]), .dm_we_i(we[1]), .dm_addr_i(addr_i[1]),
        .dm_wbe_n_i(wbe_n[1]), .dm_wdata_i(wdata_i[1]), .dm_rdata_o(rdata[1]),
        .dm_stall_o(stall[1]), .sram_addr_o(s_addr[1]), .sram_ce_n_o(ce_n[1]),
        .sram_oe_n_o(oe_n[1]), .sram_we_n_o(we_n[1]), .sram_be_n_o(be_n[1]),
        .sram_wdata_o(s_wdata[1]), .sram_data_oe_o(d_oe[1]), .sram_rdata_i(s_rdata[1])
    );

    // Behavioural SRAM: a lane is written on every clock where ce_n and we_n are low.
    logic [31:0] mem [2][16];

    always @(posedge clk) begin
        if (init) begin
            for (int d = 0; d < 2; d++) begin
                for (int w = 0; w < 16; w++) mem[d][w] <= '0;
                mem[d][4] <= 32'hDEAD_BEEF;
                mem[d][1] <= 32'h1122_3344;
            end
        end else begin
            for (int d = 0; d < 2; d++)
                if (!ce_n[d] && !we_n[d])
                    for (int b = 0; b < 4; b++)
                        if (!be_n[d][b]) mem[d][s_addr[d]][8*b +: 8] <= s_wdata[d][8*b +: 8];
        end
    end

    always_comb begin
        for (int d = 0; d < 2; d++)
            s_rdata[d] = (!ce_n[d] && !oe_n[d]) ? mem[d][s_addr[d]] : 32'h0BAD_0BAD;
    end

    typedef struct {
        int unsigned d;
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wbe_n;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int unsigned exp_stall;
        int unsigned exp_oe;
        int unsigned exp_we;
        int unsigned exp_doe;
        int unsigned exp_gap;
    } txn_t;

    int  total = 0;
    int  bad   = 0;
    time prev_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            re[d] = 1'b0; we[d] = 1'b0; addr_i[d] = '0; wbe_n[d] = 4'hF; wdata_i[d] = '0;
        end
    endtask

    // Called just after a rising edge; request is dropped after the DONE cycle.
    task automatic run_txn(input string name, input txn_t t);
        int unsigned st = 0, oe = 0, wr = 0, doe = 0;
        logic        addr_ok = 1'b1;
        logic        done = 1'b0;
        re[t.d] = t.re; we[t.d] = t.we; addr_i[t.d] = t.addr;
        wbe_n[t.d] = t.wbe_n; wdata_i[t.d] = t.wdata;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (stall[t.d]) st++;
            else            done = 1'b1;
            if (!oe_n[t.d]) oe++;
            if (!we_n[t.d]) wr++;
            if (d_oe[t.d])  doe++;
            if (!ce_n[t.d] && (s_addr[t.d] != AW'(t.addr >> 2))) addr_ok = 1'b0;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL %s timeout: no DONE within 20 cycles", name);
        end else begin
            chk({name, " rdata"}, rdata[t.d], t.exp_rd);
            chk({name, " stall"}, st, t.exp_stall);
            chk({name, " oe_n"}, oe, t.exp_oe);
            chk({name, " we_n"}, wr, t.exp_we);
            chk({name, " data_oe"}, doe, t.exp_doe);
            chk({name, " addr"}, {31'd0, addr_ok}, 32'd1);
            if (t.exp_gap != 0) chk({name, " gap"}, 32'($time - prev_done), t.exp_gap);
            prev_done = $time;
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    txn_t tbl[13];

    initial begin
        logic ok;
        txn_t t;
        //              d re we addr        wbe   wdata         exp_rd        st oe we doe gap
        tbl[0]  = '{0, 1, 0, 32'h10, 4'h0, 32'h0,         32'hDEAD_BEEF, 3, 2, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 32'h04, 4'h0, 32'h0,         32'h1122_3344, 3, 2, 0, 0, 0};
        tbl[2]  = '{0, 0, 1, 32'h07, 4'h7, 32'hAB00_0000, 32'h1122_3344, 4, 0, 2, 3, 0};
        tbl[3]  = '{0, 1, 0, 32'h04, 4'h0, 32'h0,         32'hAB22_3344, 3, 2, 0, 0, 40};
        tbl[4]  = '{0, 0, 1, 32'h50, 4'h0, 32'hCAFE_F00D, 32'hAB22_3344, 4, 0, 2, 3, 0};
        tbl[5]  = '{0, 1, 0, 32'h13, 4'h0, 32'h0,         32'hCAFE_F00D, 3, 2, 0, 0, 40};
        tbl[6]  = '{0, 0, 1, 32'h08, 4'hC, 32'h0000_5566, 32'hCAFE_F00D, 4, 0, 2, 3, 0};
        tbl[7]  = '{0, 1, 0, 32'h0A, 4'h0, 32'h0,         32'h0000_5566, 3, 2, 0, 0, 40};
        tbl[8]  = '{0, 1, 1, 32'h0C, 4'h0, 32'h7777_7777, 32'h0000_5566, 4, 0, 2, 3, 0};
        tbl[9]  = '{0, 1, 0, 32'h0C, 4'h0, 32'h0,         32'h7777_7777, 3, 2, 0, 0, 40};
        tbl[10] = '{1, 1, 0, 32'h10, 4'h0, 32'h0,         32'hDEAD_BEEF, 2, 1, 0, 0, 0};
        tbl[11] = '{1, 0, 1, 32'h0C, 4'h0, 32'h1234_5678, 32'hDEAD_BEEF, 3, 0, 1, 2, 0};
        tbl[12] = '{1, 1, 0, 32'h0C, 4'h0, 32'h0,         32'h1234_5678, 2, 1, 0, 0, 30};

        idle_inputs();
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; init = 1'b0;

        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d strobes", d), {28'd0, ce_n[d], oe_n[d], we_n[d], d_oe[d]}, 32'hE);
            chk($sformatf("rst%0d be_n", d), be_n[d], 32'hF);
            chk($sformatf("rst%0d addr", d), s_addr[d], 32'h0);
            chk($sformatf("rst%0d data", d), rdata[d] | s_wdata[d], 32'h0);
            chk($sformatf("rst%0d stall", d), stall[d], 32'h0);
        end

        // Load with every byte lane disabled must not start an access.
        @(posedge clk); #1;
        re[0] = 1'b1; addr_i[0] = 32'h10; wbe_n[0] = 4'hF;
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (stall[0] || !ce_n[0] || !oe_n[0] || !we_n[0] || d_oe[0]) ok = 1'b0;
        end
        chk("noaccess", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        idle_inputs();

        for (int i = 0; i < 13; i++) run_txn($sformatf("row%0d", i), tbl[i]);

        // Reset during the first WR cycle.
        re[0] = 1'b0; we[0] = 1'b1; addr_i[0] = 32'h18; wbe_n[0] = 4'h0; wdata_i[0] = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        chk("midwr we_n", we_n[0], 32'h0);
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        chk("midwr strobes", {28'd0, ce_n[0], oe_n[0], we_n[0], d_oe[0]}, 32'hE);
        chk("midwr stall", stall[0], 32'h0);
        chk("midwr rdata", rdata[0], 32'h0);
        rst = 1'b0;
        t = '{0, 1, 0, 32'h10, 4'h0, 32'h0, 32'hCAFE_F00D, 3, 2, 0, 0, 0};
        run_txn("postrst", t);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
